// File: rtl/stw_ctrl_pkg.sv
// Shared types and constants for the STW self-test sweep controller.
package stw_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_EVAL,
        S_NEXT,
        S_REPAIR,
        S_DONE
    } stw_state_e;

    // Test vector {mult_op1, mult_op2, add_op, expected}; offsets count WORD_SIZE words from the LSB.
    localparam int TV_WORDS        = 4;
    localparam int TV_EXPECTED_OFS = 0;
    localparam int TV_ADD_OP_OFS   = 1;
    localparam int TV_MULT_OP2_OFS = 2;
    localparam int TV_MULT_OP1_OFS = 3;

    localparam int STW_DEFAULT_TIMEOUT_CYC = 15;

endpackage

// File: rtl/stw_proxy_picker.sv
// Priority encoder: lowest-index spare that is healthy and not yet used as a proxy.
module stw_proxy_picker #(
    parameter int NUM_PE = 16,
    parameter int IW     = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] spare_mask,
    input  logic [NUM_PE-1:0] fault_map,
    input  logic [NUM_PE-1:0] assigned,
    output logic              found,
    output logic [IW-1:0]     index
);
    logic [NUM_PE-1:0] eligible;

    assign eligible = spare_mask & ~fault_map & ~assigned;

    // Descending scan so the last hit, i.e. the lowest eligible index, wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/stw_sweep_controller.sv
// Sequences a self-test over every PE, records faults, then maps faulty PEs onto spare proxies.
// Optional feature macro: STW_TIMEOUT_EN (bounds the wait on each PE's completion).
module stw_sweep_controller
    import stw_ctrl_pkg::*;
#(
    parameter int NUM_PE      = 16,
    parameter int WORD_SIZE   = 16,
    parameter int TIMEOUT_CYC = STW_DEFAULT_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sweep_start,
    input  logic [NUM_PE-1:0]             spare_mask,
    input  logic [TV_WORDS*WORD_SIZE-1:0] tv_in,
    output logic [TV_WORDS*WORD_SIZE-1:0] tv_out,
    output logic [NUM_PE-1:0]             stw_test_load_en,
    output logic [NUM_PE-1:0]             stw_start,
    input  logic [NUM_PE-1:0]             stw_complete,
    input  logic [NUM_PE-1:0]             stw_result,
    output logic                          array_stall,
    output logic [NUM_PE-1:0]             fault_map,
    output logic                          proxy_valid,
    output logic [$clog2(NUM_PE)-1:0]     proxy_src,
    output logic [$clog2(NUM_PE)-1:0]     proxy_dst,
    output logic                          unrepaired,
    output logic                          busy,
    output logic                          done
);
    localparam int                IW     = $clog2(NUM_PE);
    localparam logic [NUM_PE-1:0] PE_ONE = NUM_PE'(1);

    if (NUM_PE < 2) begin : g_bad_num_pe
        $error("stw_sweep_controller: NUM_PE must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("stw_sweep_controller: TIMEOUT_CYC must be at least 1");
    end

    stw_state_e        state, state_d;
    logic [IW-1:0]     idx, idx_d;
    logic [NUM_PE-1:0] fault_d, assigned, assigned_d;
    logic              unrep_d, latch_tv, proxy_fire, last_pe;
    logic              pick_found;
    logic [IW-1:0]     pick_index;

    assign last_pe = (idx == IW'(NUM_PE - 1));

    stw_proxy_picker #(
        .NUM_PE (NUM_PE),
        .IW     (IW)
    ) u_picker (
        .spare_mask (spare_mask),
        .fault_map  (fault_map),
        .assigned   (assigned),
        .found      (pick_found),
        .index      (pick_index)
    );

`ifdef STW_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;
    logic          timed_out;

    // Trips once the combined WAIT_LO+WAIT_HI time has gone past TIMEOUT_CYC cycles.
    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_START) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT_LO || state == S_WAIT_HI) && !timed_out) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
`endif

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        fault_d    = fault_map;
        unrep_d    = unrepaired;
        assigned_d = assigned;
        latch_tv   = 1'b0;
        proxy_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (sweep_start) begin
                    latch_tv   = 1'b1;
                    fault_d    = '0;
                    unrep_d    = 1'b0;
                    assigned_d = '0;
                    idx_d      = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!stw_complete[idx]) begin
                    state_d = S_WAIT_HI;
                end
`ifdef STW_TIMEOUT_EN
                else if (timed_out) begin
                    fault_d[idx] = 1'b1;
                    state_d      = S_NEXT;
                end
`endif
            end
            S_WAIT_HI: begin
                if (stw_complete[idx]) begin
                    state_d = S_EVAL;
                end
`ifdef STW_TIMEOUT_EN
                else if (timed_out) begin
                    fault_d[idx] = 1'b1;
                    state_d      = S_NEXT;
                end
`endif
            end
            S_EVAL: begin
                if (!stw_result[idx]) begin
                    fault_d[idx] = 1'b1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_pe) begin
                    idx_d   = '0;
                    state_d = S_REPAIR;
                end else begin
                    idx_d   = idx + IW'(1);
                    state_d = S_LOAD;
                end
            end
            S_REPAIR: begin
                // Faulty spares are only recorded; they never need a proxy themselves.
                if (fault_map[idx] && !spare_mask[idx]) begin
                    if (pick_found) begin
                        proxy_fire             = 1'b1;
                        assigned_d[pick_index] = 1'b1;
                    end else begin
                        unrep_d = 1'b1;
                    end
                end
                if (last_pe) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they are glitch-free and line up with the state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            idx              <= '0;
            assigned         <= '0;
            tv_out           <= '0;
            stw_test_load_en <= '0;
            stw_start        <= '0;
            fault_map        <= '0;
            unrepaired       <= 1'b0;
            proxy_valid      <= 1'b0;
            proxy_src        <= '0;
            proxy_dst        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            assigned   <= assigned_d;
            fault_map  <= fault_d;
            unrepaired <= unrep_d;
            if (latch_tv) begin
                tv_out[TV_EXPECTED_OFS*WORD_SIZE +: WORD_SIZE] <= tv_in[TV_EXPECTED_OFS*WORD_SIZE +: WORD_SIZE];
                tv_out[TV_ADD_OP_OFS*WORD_SIZE   +: WORD_SIZE] <= tv_in[TV_ADD_OP_OFS*WORD_SIZE   +: WORD_SIZE];
                tv_out[TV_MULT_OP2_OFS*WORD_SIZE +: WORD_SIZE] <= tv_in[TV_MULT_OP2_OFS*WORD_SIZE +: WORD_SIZE];
                tv_out[TV_MULT_OP1_OFS*WORD_SIZE +: WORD_SIZE] <= tv_in[TV_MULT_OP1_OFS*WORD_SIZE +: WORD_SIZE];
            end
            stw_test_load_en <= (state_d == S_LOAD)  ? (PE_ONE << idx_d) : '0;
            stw_start        <= (state_d == S_START) ? (PE_ONE << idx_d) : '0;
            busy             <= (state_d != S_IDLE);
            done             <= (state_d == S_DONE);
            proxy_valid      <= proxy_fire;
            if (proxy_fire) begin
                proxy_src <= idx;
                proxy_dst <= pick_index;
            end
        end
    end

    assign array_stall = busy;

endmodule

// File: tb/tb_stw_sweep_controller.sv
// Randomized and directed bench for stw_sweep_controller with a behavioural PE-array and repair model.
module tb_stw_sweep_controller;

    localparam int NP = 4;
    localparam int WS = 16;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            sweep_start;
    logic [NP-1:0]   spare_mask;
    logic [4*WS-1:0] tv_in;
    logic [4*WS-1:0] tv_out;
    logic [NP-1:0]   load_en, start_s, fault_map;
    logic            array_stall, proxy_valid, unrepaired, busy, done;
    logic [1:0]      proxy_src, proxy_dst;

    logic [NP-1:0]   pe_complete = '1;
    logic [NP-1:0]   pe_fail     = '0;
    logic [NP-1:0]   pe_stuck    = '0;
    int              lo_cnt[NP];

    logic [4:0]      strobe_log[$];
    logic [1:0]      obs_src[$], obs_dst[$];
    logic [1:0]      exp_src[$], exp_dst[$];
    logic            exp_unrep;
    int              done_cnt;
    int              passed = 0;
    int              total  = 0;

    stw_sweep_controller #(
        .NUM_PE      (NP),
        .WORD_SIZE   (WS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sweep_start      (sweep_start),
        .spare_mask       (spare_mask),
        .tv_in            (tv_in),
        .tv_out           (tv_out),
        .stw_test_load_en (load_en),
        .stw_start        (start_s),
        .stw_complete     (pe_complete),
        .stw_result       (~pe_fail),
        .array_stall      (array_stall),
        .fault_map        (fault_map),
        .proxy_valid      (proxy_valid),
        .proxy_src        (proxy_src),
        .proxy_dst        (proxy_dst),
        .unrepaired       (unrepaired),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // PE array model (complete drops after start, rises again 3 cycles later) plus output monitor.
    always @(negedge clk) begin
        if (rst) begin
            pe_complete = '1;
            for (int i = 0; i < NP; i++) lo_cnt[i] = 0;
        end else begin
            if (load_en != '0) strobe_log.push_back({1'b0, load_en});
            if (start_s != '0) strobe_log.push_back({1'b1, start_s});
            for (int i = 0; i < NP; i++) begin
                if (lo_cnt[i] != 0) begin
                    lo_cnt[i] = lo_cnt[i] - 1;
                    if (lo_cnt[i] == 0) pe_complete[i] = 1'b1;
                end
                if (start_s[i] && !pe_stuck[i]) begin
                    pe_complete[i] = 1'b0;
                    lo_cnt[i]      = 3;
                end
            end
            if (proxy_valid) begin
                obs_src.push_back(proxy_src);
                obs_dst.push_back(proxy_dst);
            end
            if (done) done_cnt++;
        end
    end

    // Repair reference: walk PEs in order, give each faulty worker the lowest free healthy spare.
    task automatic build_expected(input logic [NP-1:0] faults, input logic [NP-1:0] spares);
        bit used[NP];
        int pick;
        exp_src.delete();
        exp_dst.delete();
        exp_unrep = 1'b0;
        for (int i = 0; i < NP; i++) used[i] = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (faults[i] && !spares[i]) begin
                pick = -1;
                for (int j = 0; j < NP; j++)
                    if (pick < 0 && spares[j] && !faults[j] && !used[j]) pick = j;
                if (pick < 0) begin
                    exp_unrep = 1'b1;
                end else begin
                    used[pick] = 1'b1;
                    exp_src.push_back(2'(i));
                    exp_dst.push_back(2'(pick));
                end
            end
        end
    endtask

    task automatic run_sweep(input logic [NP-1:0] fail, input logic [NP-1:0] stuck, input logic [4*WS-1:0] tv);
        int cyc;
        pe_fail  = fail;
        pe_stuck = stuck;
        strobe_log.delete();
        obs_src.delete();
        obs_dst.delete();
        done_cnt = 0;
        @(negedge clk);
        tv_in       = tv;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        tv_in       = {$urandom, $urandom};
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1) $display("FAIL sweep_end: done not seen after %0d cycles", cyc);
        else passed++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic verify_sweep(input string name, input logic [NP-1:0] faults, input logic [4*WS-1:0] tv);
        logic [4:0] e;
        build_expected(faults, spare_mask);
        total++;
        if (fault_map !== faults) $display("FAIL %s fault_map: got %b want %b", name, fault_map, faults);
        else passed++;
        total++;
        if (unrepaired !== exp_unrep) $display("FAIL %s unrepaired: got %b want %b", name, unrepaired, exp_unrep);
        else passed++;
        total++;
        if (obs_src.size() != exp_src.size())
            $display("FAIL %s proxy_count: got %0d want %0d", name, obs_src.size(), exp_src.size());
        else passed++;
        for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++) begin
            total++;
            if (obs_src[k] !== exp_src[k] || obs_dst[k] !== exp_dst[k])
                $display("FAIL %s proxy[%0d]: got %0d->%0d want %0d->%0d", name, k,
                         obs_src[k], obs_dst[k], exp_src[k], exp_dst[k]);
            else passed++;
        end
        total++;
        if (done_cnt != 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
        else passed++;
        total++;
        if (busy !== 1'b0 || array_stall !== 1'b0)
            $display("FAIL %s idle_after: busy=%b stall=%b want 0 0", name, busy, array_stall);
        else passed++;
        total++;
        if (tv_out !== tv) $display("FAIL %s tv_out: got %h want %h", name, tv_out, tv);
        else passed++;
        total++;
        if (strobe_log.size() != 2 * NP)
            $display("FAIL %s strobe_count: got %0d want %0d", name, strobe_log.size(), 2 * NP);
        else passed++;
        for (int k = 0; k < 2 * NP && k < strobe_log.size(); k++) begin
            e = {k[0], 4'b0001 << (k / 2)};
            total++;
            if (strobe_log[k] !== e) $display("FAIL %s strobe[%0d]: got %b want %b", name, k, strobe_log[k], e);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        sweep_start = 1'b0;
        spare_mask  = 4'b1000;
        tv_in       = {$urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        total++;
        if (tv_out !== '0) $display("FAIL reset tv_out: got %h want 0", tv_out); else passed++;
        total++;
        if (load_en !== '0 || start_s !== '0)
            $display("FAIL reset strobes: got %b %b want 0 0", load_en, start_s);
        else passed++;
        total++;
        if (fault_map !== '0 || unrepaired !== 1'b0)
            $display("FAIL reset status: got %b %b want 0 0", fault_map, unrepaired);
        else passed++;
        total++;
        if ({proxy_valid, proxy_src, proxy_dst} !== 5'b0)
            $display("FAIL reset proxy: got %b want 0", {proxy_valid, proxy_src, proxy_dst});
        else passed++;
        total++;
        if ({busy, array_stall, done} !== 3'b0)
            $display("FAIL reset busy_stall_done: got %b want 000", {busy, array_stall, done});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [4*WS-1:0] tv;
        spare_mask = 4'b1000;
        tv = {$urandom, $urandom};
        run_sweep(4'b0000, 4'b0000, tv);
        verify_sweep("all_pass", 4'b0000, tv);
        total++;
        if (obs_src.size() != 0 || unrepaired !== 1'b0)
            $display("FAIL all_pass literal: proxies=%0d unrep=%b want 0 0", obs_src.size(), unrepaired);
        else passed++;

        tv = {$urandom, $urandom};
        run_sweep(4'b0010, 4'b0000, tv);
        verify_sweep("pe1_fail", 4'b0010, tv);
        total++;
        if (obs_src.size() != 1 || obs_src[0] !== 2'd1 || obs_dst[0] !== 2'd3 || unrepaired !== 1'b0)
            $display("FAIL pe1_fail literal: proxies=%0d unrep=%b want one 1->3 and 0", obs_src.size(), unrepaired);
        else passed++;

        tv = {$urandom, $urandom};
        run_sweep(4'b0110, 4'b0000, tv);
        verify_sweep("pe12_fail", 4'b0110, tv);
        total++;
        if (obs_src.size() != 1 || obs_src[0] !== 2'd1 || obs_dst[0] !== 2'd3 || unrepaired !== 1'b1)
            $display("FAIL pe12_fail literal: proxies=%0d unrep=%b want one 1->3 and 1", obs_src.size(), unrepaired);
        else passed++;

        tv = {$urandom, $urandom};
        run_sweep(4'b1001, 4'b0000, tv);
        verify_sweep("pe0_spare_fail", 4'b1001, tv);
        total++;
        if (obs_src.size() != 0 || unrepaired !== 1'b1)
            $display("FAIL pe0_spare_fail literal: proxies=%0d unrep=%b want 0 1", obs_src.size(), unrepaired);
        else passed++;
    endtask

    task automatic test_random;
        logic [NP-1:0]   f;
        logic [4*WS-1:0] tv;
        string           nm;
        for (int it = 0; it < 12; it++) begin
            spare_mask = 4'($urandom_range(0, 15));
            f          = 4'($urandom_range(0, 15));
            tv         = {$urandom, $urandom};
            nm         = $sformatf("rand%0d", it);
            run_sweep(f, 4'b0000, tv);
            verify_sweep(nm, f, tv);
        end
        spare_mask = 4'b1000;
    endtask

    task automatic test_back_to_back;
        logic [4*WS-1:0] tva, tvb;
        int              cyc;
        tva = {$urandom, $urandom};
        tvb = {$urandom, $urandom};
        pe_fail  = 4'b0100;
        pe_stuck = 4'b0000;
        @(negedge clk);
        tv_in       = tva;
        sweep_start = 1'b1;
        @(negedge clk);
        tv_in = tvb;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || tv_out !== tva)
            $display("FAIL b2b first: done=%b tv_out=%h want 1 %h", done, tv_out, tva);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL b2b idle_gap: busy=%b want 0", busy); else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || load_en !== 4'b0001 || tv_out !== tvb)
            $display("FAIL b2b restart: busy=%b load=%b tv_out=%h want 1 0001 %h", busy, load_en, tv_out, tvb);
        else passed++;
        sweep_start = 1'b0;
        pe_fail     = 4'b0000;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        total++;
        if (fault_map !== 4'b0000 || busy !== 1'b0)
            $display("FAIL b2b second: fault_map=%b busy=%b want 0000 0", fault_map, busy);
        else passed++;
    endtask

`ifdef STW_TIMEOUT_EN
    task automatic test_timeout;
        logic [4*WS-1:0] tv;
        spare_mask = 4'b1000;
        tv = {$urandom, $urandom};
        run_sweep(4'b0000, 4'b0100, tv);
        verify_sweep("timeout_pe2", 4'b0100, tv);
        pe_stuck = 4'b0000;
    endtask
`endif

    task automatic test_reset_mid_sweep;
        int cyc;
        pe_fail  = 4'b0001;
        pe_stuck = 4'b0000;
        @(negedge clk);
        tv_in       = {$urandom, $urandom};
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        cyc = 0;
        while (start_s !== 4'b0010 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (start_s !== 4'b0010) $display("FAIL mid_rst start_pe1: got %b want 0010", start_s); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || fault_map !== 4'b0001)
            $display("FAIL mid_rst pre: busy=%b fault_map=%b want 1 0001", busy, fault_map);
        else passed++;
        #1 rst = 1'b1;
        #1;
        total++;
        if ({tv_out, load_en, start_s, array_stall, fault_map, proxy_valid, proxy_src, proxy_dst,
             unrepaired, busy, done} !== '0)
            $display("FAIL mid_rst outputs: tv=%h ld=%b st=%b fm=%b busy=%b stall=%b want all 0",
                     tv_out, load_en, start_s, fault_map, busy, array_stall);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (load_en !== '0 || start_s !== '0 || busy !== 1'b0)
            $display("FAIL mid_rst release: ld=%b st=%b busy=%b want 0 0 0", load_en, start_s, busy);
        else passed++;
        strobe_log.delete();
        pe_fail     = 4'b0000;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        cyc = 0;
        while (strobe_log.size() == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (strobe_log.size() == 0 || strobe_log[0] !== 5'b00001)
            $display("FAIL mid_rst first_strobe: log_size=%0d want load of PE0", strobe_log.size());
        else passed++;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        done_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
`ifdef STW_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
